bcd_timer_ctrl: RTL and testbench
=================================

# bcd_timer_ctrl

Sequencing controller for a chain of BCD digit counters. It presets the chain from a BCD value, gates counting through a clock prescaler, ripples decade carries between digits, and stops the count when the chain reaches a programmed BCD limit. It is the run/pause/terminal-count control layer that sits above the single-digit load/count counter datapath in the lab designs.

## Interface
- `DIGITS`, default 2: number of BCD digits in the chain (≥1).
- `PRESCALE`, default 4: CLK cycles per count tick (≥1; 1 means a tick every cycle).

- `CLK`  in  1  system clock, rising edge.
- `Clear_b`  in  1  reset, asynchronous, active-low.
- `Start`  in  1  level-sampled each edge; start or resume counting.
- `Stop`  in  1  level-sampled each edge; pause, or return to idle.
- `Preset_load`  in  1  load `Preset` into the chain (IDLE/DONE only).
- `Preset`  in  4*DIGITS  BCD preset value; digit 0 is bits [3:0].
- `Limit`  in  4*DIGITS  BCD terminal value.
- `Count_value`  out  4*DIGITS  current chain value.
- `State`  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
- `Busy`  out  1  high in RUN or PAUSE.
- `Done`  out  1  one-cycle pulse on entry to DONE.
- `Wrap`  out  1  one-cycle pulse when the chain rolls from all-9s to all-0s.
- `Load_err`  out  1  sticky; the last `Preset_load` carried a nibble >9.

## Operation
- Reset values: `Count_value`=0, `State`=IDLE, prescaler=0, `Busy`=`Done`=`Wrap`=`Load_err`=0.
- IDLE:
  - `Preset_load` with all nibbles ≤9 loads the chain and clears `Load_err`. With any nibble >9, the chain is unchanged and `Load_err`=1.
  - `Start` moves to RUN and clears the prescaler.
- RUN:
  - The prescaler counts 0..PRESCALE-1. A tick occurs on the edge where it equals PRESCALE-1; that edge also returns it to 0.
  - On a tick, digit 0 increments. Digit i increments when all lower digits equal 9. A digit at 9 goes to 0.
  - If the post-increment value equals `Limit`, enter DONE.
  - `Stop` moves to PAUSE; the prescaler value is held.
- PAUSE:
  - `Start` returns to RUN, and the prescaler resumes from its held value.
  - `Stop` moves to IDLE with the value retained.
- DONE:
  - The value is held.
  - `Stop` moves to IDLE.
  - `Preset_load` loads the chain (same check as IDLE) and moves to IDLE.
  - `Start` is ignored.
- Priority: `Stop` beats `Start` when both are high in the same cycle. `Preset_load` outside IDLE/DONE is ignored.
- Limit handling:
  - The limit compare applies only to tick-produced values. Starting with `Count_value`==`Limit` runs a full 10^DIGITS ticks before DONE.
  - A `Limit` containing a nibble >9 never matches; the chain wraps indefinitely.
- Wrap: rollover from all-9s pulses `Wrap`. When the wrapped value 0 equals `Limit`, `Wrap` and `Done` pulse together.

## Timing
- All outputs are registered.
- Latencies:
  - `Start` sampled at edge k gives `State`=RUN after edge k.
  - From IDLE, the first tick lands at edge k+PRESCALE, and `Count_value` changes at that edge.
  - `Done` and `Wrap` are high for exactly the one cycle following the edge that produced the matching or rolled value.
- Reset: assertion of `Clear_b` mid-operation forces all reset values immediately, independent of CLK. Operation resumes from IDLE on the first edge after release.

## Structure
- Package `bcd_timer_pkg`:
  - state encoding constants (IDLE/RUN/PAUSE/DONE);
  - `BCD_MAX`=4'd9;
  - nibble width constant 4.
- Sub-module `bcd_digit`: one 4-bit digit with load, increment-enable, and carry-out (= digit==9 & enable). Instantiate it DIGITS times with a generate loop.
- The top level holds the FSM, prescaler, preset validation, limit comparator, and pulse outputs.

## Test plan
All scenarios use DIGITS=2, PRESCALE=4.
1. Reset: pull `Clear_b` low mid-RUN at `Count_value`=0x37 → all outputs 0 and `State`=00 before the next edge; after release, `Start` restarts from 00.
2. Basic run: Preset 0x07, Limit 0x12, then `Start` → sequence 07,08,09,10,11,12 at 4-cycle intervals. The 09→10 step carries. `Done` pulses one cycle, `State`=11, and the value holds at 12.
3. Rollover: Preset 0x98, Limit 0x03 → 99, 00 with `Wrap` pulse, 01, 02, 03 with `Done` pulse.
4. Pause: `Stop` two cycles after the tick to 0x05 → PAUSE, value 05 held for 20 cycles. `Start` → 06 arrives exactly 2 cycles after RUN re-entry. `Stop` in PAUSE → IDLE, 06 retained.
5. Load checks:
   - Preset 0x1A → `Load_err`=1, value unchanged.
   - Preset 0x42 → `Load_err`=0, value 42.
   - `Preset_load` during RUN → ignored.
6. Edge cases:
   - `Start` and `Stop` high together in RUN → PAUSE.
   - Start with value == Limit == 0x50 → DONE only after 100 ticks, with `Wrap` seen once.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// ---------------------------------------------------------------------------
// bcd_timer_pkg : shared encodings and helpers for the BCD timer controller
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_timer_pkg;

  localparam int NIB_W = 4;
  localparam logic [NIB_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } timer_state_e;

  function automatic logic nib_is_bcd(input logic [NIB_W-1:0] n);
    return (n <= BCD_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_timer_ctrl_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit : one decade counter digit with load, increment and carry-out
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [NIB_W-1:0] load_val_i,
  input  logic             inc_i,
  output logic [NIB_W-1:0] q_o,
  output logic [NIB_W-1:0] nxt_o,
  output logic             carry_o
);

  logic [NIB_W-1:0] digit_q;
  logic [NIB_W-1:0] digit_d;
  logic [NIB_W-1:0] inc_val;

  always_comb begin
    inc_val = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
    nxt_o   = inc_i ? inc_val : digit_q;
    digit_d = load_i ? load_val_i : nxt_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign q_o     = digit_q;
  assign carry_o = inc_i && (digit_q == BCD_MAX);

endmodule

`default_nettype wire

// File: rtl/bcd_timer_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_timer_ctrl : run/pause/terminal-count control over a BCD digit chain
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 4
) (
  input  logic                  CLK,
  input  logic                  Clear_b,
  input  logic                  Start,
  input  logic                  Stop,
  input  logic                  Preset_load,
  input  logic [4*DIGITS-1:0]   Preset,
  input  logic [4*DIGITS-1:0]   Limit,
  output logic [4*DIGITS-1:0]   Count_value,
  output logic [1:0]            State,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Wrap,
  output logic                  Load_err
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  timer_state_e         state_q;
  logic [PW-1:0]        pre_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 wrap_q;
  logic                 lerr_q;

  logic                 preset_ok;
  logic                 tick;
  logic                 load_en;
  logic                 hit;
  logic [DIGITS:0]      carry;
  logic [4*DIGITS-1:0]  nxt_value;

  always_comb begin
    preset_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!nib_is_bcd(Preset[i*NIB_W +: NIB_W])) preset_ok = 1'b0;
    end
  end

  assign tick     = (state_q == ST_RUN) && (pre_q == PRE_LAST);
  assign load_en  = Preset_load && preset_ok &&
                    ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign carry[0] = tick;
  // nxt_value only ever holds valid BCD, so a Limit with a nibble >9 never matches
  assign hit      = tick && (nxt_value == Limit);

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .clk        (CLK),
        .rst_n      (Clear_b),
        .load_i     (load_en),
        .load_val_i (Preset[g*NIB_W +: NIB_W]),
        .inc_i      (carry[g]),
        .q_o        (Count_value[g*NIB_W +: NIB_W]),
        .nxt_o      (nxt_value[g*NIB_W +: NIB_W]),
        .carry_o    (carry[g+1])
      );
    end
  endgenerate

  // The prescaler advances on every edge spent in RUN, including the edge that samples Stop.
  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= carry[DIGITS];
      case (state_q)
        ST_IDLE: begin
          if (Preset_load) lerr_q <= !preset_ok;
          if (Start && !Stop) begin
            state_q <= ST_RUN;
            pre_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          pre_q <= tick ? '0 : pre_q + PW'(1);
          // A terminal match completes the count even if Stop arrives on the same edge
          if (hit) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (Stop) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (Stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (Start) begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (Preset_load) begin
            lerr_q  <= !preset_ok;
            state_q <= ST_IDLE;
          end
          if (Stop) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign State    = state_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Wrap     = wrap_q;
  assign Load_err = lerr_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_timer_ctrl : directed vector bench for bcd_timer_ctrl (2 digits, /4)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bcd_timer_ctrl;

  logic       CLK;
  logic       Clear_b;
  logic       Start;
  logic       Stop;
  logic       Preset_load;
  logic [7:0] Preset;
  logic [7:0] Limit;
  logic [7:0] Count_value;
  logic [1:0] State;
  logic       Busy;
  logic       Done;
  logic       Wrap;
  logic       Load_err;

  int n_chk  = 0;
  int n_fail = 0;

  bcd_timer_ctrl #(.DIGITS(2), .PRESCALE(4)) dut (
    .CLK         (CLK),
    .Clear_b     (Clear_b),
    .Start       (Start),
    .Stop        (Stop),
    .Preset_load (Preset_load),
    .Preset      (Preset),
    .Limit       (Limit),
    .Count_value (Count_value),
    .State       (State),
    .Busy        (Busy),
    .Done        (Done),
    .Wrap        (Wrap),
    .Load_err    (Load_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       st;
    logic       sp;
    logic       pl;
    logic [7:0] pre;
    logic [7:0] lim;
    int         n;
    logic [7:0] cnt;
    logic [1:0] state;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       lerr;
  } vec_t;

  localparam int NV = 36;
  vec_t tv [NV];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] cnt, input logic [1:0] st,
                         input logic bsy, input logic dn, input logic wr, input logic le);
    chk({tag, ".count"}, 32'(Count_value), 32'(cnt));
    chk({tag, ".state"}, 32'(State), 32'(st));
    chk({tag, ".busy"},  32'(Busy), 32'(bsy));
    chk({tag, ".done"},  32'(Done), 32'(dn));
    chk({tag, ".wrap"},  32'(Wrap), 32'(wr));
    chk({tag, ".lerr"},  32'(Load_err), 32'(le));
  endtask

  task automatic run_vec(input int i);
    Start       = tv[i].st;
    Stop        = tv[i].sp;
    Preset_load = tv[i].pl;
    Preset      = tv[i].pre;
    Limit       = tv[i].lim;
    step();
    Start       = 1'b0;
    Stop        = 1'b0;
    Preset_load = 1'b0;
    for (int c = 1; c < tv[i].n; c++) step();
    chk_all($sformatf("vec%0d", i), tv[i].cnt, tv[i].state, tv[i].busy,
            tv[i].done, tv[i].wrap, tv[i].lerr);
  endtask

  initial begin
    int wraps;
    int done_cyc;

    //        st  sp  pl  pre    lim    n   cnt    state  bsy dn  wr  le
    // basic run 07 -> 12 with a carry at 09->10
    tv[0]  = '{0, 0, 1, 8'h07, 8'h12, 1,  8'h07, 2'b00, 0, 0, 0, 0};
    tv[1]  = '{1, 0, 0, 8'h00, 8'h12, 1,  8'h07, 2'b01, 1, 0, 0, 0};
    tv[2]  = '{0, 0, 0, 8'h00, 8'h12, 4,  8'h08, 2'b01, 1, 0, 0, 0};
    tv[3]  = '{0, 0, 0, 8'h00, 8'h12, 4,  8'h09, 2'b01, 1, 0, 0, 0};
    tv[4]  = '{0, 0, 0, 8'h00, 8'h12, 4,  8'h10, 2'b01, 1, 0, 0, 0};
    tv[5]  = '{0, 0, 0, 8'h00, 8'h12, 4,  8'h11, 2'b01, 1, 0, 0, 0};
    tv[6]  = '{0, 0, 0, 8'h00, 8'h12, 4,  8'h12, 2'b11, 0, 1, 0, 0};
    tv[7]  = '{0, 0, 0, 8'h00, 8'h12, 1,  8'h12, 2'b11, 0, 0, 0, 0};
    tv[8]  = '{1, 0, 0, 8'h00, 8'h12, 1,  8'h12, 2'b11, 0, 0, 0, 0};
    tv[9]  = '{0, 1, 0, 8'h00, 8'h12, 1,  8'h12, 2'b00, 0, 0, 0, 0};
    // rollover 98 -> 99 -> 00 (Wrap) -> 01 -> 02 -> 03 (Done)
    tv[10] = '{0, 0, 1, 8'h98, 8'h03, 1,  8'h98, 2'b00, 0, 0, 0, 0};
    tv[11] = '{1, 0, 0, 8'h00, 8'h03, 1,  8'h98, 2'b01, 1, 0, 0, 0};
    tv[12] = '{0, 0, 0, 8'h00, 8'h03, 4,  8'h99, 2'b01, 1, 0, 0, 0};
    tv[13] = '{0, 0, 0, 8'h00, 8'h03, 4,  8'h00, 2'b01, 1, 0, 1, 0};
    tv[14] = '{0, 0, 0, 8'h00, 8'h03, 1,  8'h00, 2'b01, 1, 0, 0, 0};
    tv[15] = '{0, 0, 0, 8'h00, 8'h03, 3,  8'h01, 2'b01, 1, 0, 0, 0};
    tv[16] = '{0, 0, 0, 8'h00, 8'h03, 4,  8'h02, 2'b01, 1, 0, 0, 0};
    tv[17] = '{0, 0, 0, 8'h00, 8'h03, 4,  8'h03, 2'b11, 0, 1, 0, 0};
    // preset validation from DONE and IDLE
    tv[18] = '{0, 0, 1, 8'h1A, 8'h03, 1,  8'h03, 2'b00, 0, 0, 0, 1};
    tv[19] = '{0, 0, 1, 8'h42, 8'h03, 1,  8'h42, 2'b00, 0, 0, 0, 0};
    tv[20] = '{0, 0, 1, 8'h1A, 8'h03, 1,  8'h42, 2'b00, 0, 0, 0, 1};
    tv[21] = '{0, 0, 1, 8'h42, 8'h03, 1,  8'h42, 2'b00, 0, 0, 0, 0};
    // invalid limit, loads ignored in RUN, Start+Stop -> PAUSE, resume
    tv[22] = '{1, 0, 0, 8'h00, 8'hFF, 1,  8'h42, 2'b01, 1, 0, 0, 0};
    tv[23] = '{0, 0, 1, 8'h00, 8'hFF, 4,  8'h43, 2'b01, 1, 0, 0, 0};
    tv[24] = '{0, 0, 1, 8'h1A, 8'hFF, 1,  8'h43, 2'b01, 1, 0, 0, 0};
    tv[25] = '{1, 1, 0, 8'h00, 8'hFF, 1,  8'h43, 2'b10, 1, 0, 0, 0};
    tv[26] = '{0, 0, 0, 8'h00, 8'hFF, 20, 8'h43, 2'b10, 1, 0, 0, 0};
    tv[27] = '{1, 0, 0, 8'h00, 8'hFF, 1,  8'h43, 2'b01, 1, 0, 0, 0};
    tv[28] = '{0, 0, 0, 8'h00, 8'hFF, 1,  8'h43, 2'b01, 1, 0, 0, 0};
    tv[29] = '{0, 0, 0, 8'h00, 8'hFF, 1,  8'h44, 2'b01, 1, 0, 0, 0};
    tv[30] = '{0, 1, 0, 8'h00, 8'hFF, 1,  8'h44, 2'b10, 1, 0, 0, 0};
    tv[31] = '{0, 1, 0, 8'h00, 8'hFF, 1,  8'h44, 2'b00, 0, 0, 0, 0};
    // 99 -> 00 where 00 is the limit: Wrap and Done together
    tv[32] = '{0, 0, 1, 8'h99, 8'h00, 1,  8'h99, 2'b00, 0, 0, 0, 0};
    tv[33] = '{1, 0, 0, 8'h00, 8'h00, 1,  8'h99, 2'b01, 1, 0, 0, 0};
    tv[34] = '{0, 0, 0, 8'h00, 8'h00, 4,  8'h00, 2'b11, 0, 1, 1, 0};
    tv[35] = '{0, 1, 0, 8'h00, 8'h00, 1,  8'h00, 2'b00, 0, 0, 0, 0};

    Clear_b     = 1'b0;
    Start       = 1'b0;
    Stop        = 1'b0;
    Preset_load = 1'b0;
    Preset      = 8'h00;
    Limit       = 8'h00;
    step();
    step();
    chk_all("reset", 8'h00, 2'b00, 0, 0, 0, 0);
    Clear_b = 1'b1;
    step();

    for (int i = 0; i < NV; i++) run_vec(i);

    // pause 2 cycles after the tick to 05; 06 lands 2 cycles after resuming
    Limit = 8'hFF; Preset = 8'h03; Preset_load = 1'b1; step(); Preset_load = 1'b0;
    Start = 1'b1; step(); Start = 1'b0;
    for (int c = 0; c < 8; c++) step();
    chk("pause.at05", 32'(Count_value), 32'h05);
    step();
    Stop = 1'b1; step(); Stop = 1'b0;
    chk("pause.state", 32'(State), 32'(2'b10));
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("pause.hold%0d", c), {22'd0, State, Count_value}, {22'd0, 2'b10, 8'h05});
    end
    Start = 1'b1; step(); Start = 1'b0;
    chk_all("resume.0", 8'h05, 2'b01, 1, 0, 0, 0);
    step();
    chk("resume.1", 32'(Count_value), 32'h05);
    step();
    chk("resume.2", 32'(Count_value), 32'h06);
    Stop = 1'b1; step();
    chk("resume.pause", 32'(State), 32'(2'b10));
    step(); Stop = 1'b0;
    chk_all("resume.idle", 8'h06, 2'b00, 0, 0, 0, 0);

    // asynchronous reset mid-RUN at 37 with Load_err set
    Preset = 8'h30; Preset_load = 1'b1; step();
    Preset = 8'h3F; step(); Preset_load = 1'b0;
    chk("rst.lerr_set", 32'(Load_err), 32'd1);
    Start = 1'b1; step(); Start = 1'b0;
    for (int c = 0; c < 28; c++) step();
    chk_all("rst.pre", 8'h37, 2'b01, 1, 0, 0, 1);
    #3 Clear_b = 1'b0;
    #1;
    chk_all("rst.async", 8'h00, 2'b00, 0, 0, 0, 0);
    step();
    Clear_b = 1'b1;
    Start = 1'b1; step(); Start = 1'b0;
    chk_all("rst.restart", 8'h00, 2'b01, 1, 0, 0, 0);
    for (int c = 0; c < 4; c++) step();
    chk("rst.tick", 32'(Count_value), 32'h01);
    Stop = 1'b1; step(); step(); Stop = 1'b0;
    chk("rst.idle", 32'(State), 32'(2'b00));

    // start with value == limit: full 100 ticks, one Wrap
    Preset = 8'h50; Limit = 8'h50; Preset_load = 1'b1; step(); Preset_load = 1'b0;
    Start = 1'b1; step(); Start = 1'b0;
    wraps    = 0;
    done_cyc = 0;
    for (int c = 1; c <= 440; c++) begin
      step();
      if (Wrap) wraps++;
      if (Done) begin
        done_cyc = c;
        break;
      end
    end
    chk("full.done_cycle", 32'(done_cyc), 32'd400);
    chk("full.wraps", 32'(wraps), 32'd1);
    chk("full.count", 32'(Count_value), 32'h50);
    chk("full.state", 32'(State), 32'(2'b11));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
